hazard_sequencer: RTL and testbench

//   Pipeline hazard and stall sequencer for the 5-stage RV32I core.

---
 rtl/hazard_sequencer_pkg.sv | 13 +
 rtl/hazard_sequencer_hz_sat_counter.sv | 20 ++
 rtl/hazard_sequencer.sv | 125 ++++++++++++
 tb/tb_hazard_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
// Optional perf counters are enabled with HAZ_PERF_CNT_EN.
package hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1
    } hz_state_t;

    localparam int HZ_CNT_W_DEF  = 32;
    localparam int HZ_REG_AW_DEF = 5;

endpackage

// File: rtl/hazard_sequencer_hz_sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module hz_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard and stall sequencer for the 5-stage RV32I pipeline.
// Define HAZ_PERF_CNT_EN to build the saturating perf counters.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW_DEF,
    parameter int CNT_W  = HZ_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              hold_front,
    output logic              hold_back,
    output logic              flush_ifid,
    output logic              bubble_idex,
    output logic              bubble_memwb,
    output hz_state_t         seq_state,
    output logic [CNT_W-1:0]  cnt_load_use,
    output logic [CNT_W-1:0]  cnt_mem_wait,
    output logic [CNT_W-1:0]  cnt_flush
);

    hz_state_t state;

    logic mem_stall;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic take_stall;
    logic take_flush;
    logic take_lu;

    assign mem_stall = mem_req & ~mem_ready;
    assign rs1_hit   = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit   = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use  = ex_is_load & (ex_rd != '0) & (rs1_hit | rs2_hit);

    // One winner per cycle: memory stall, then redirect, then load-use.
    assign take_stall = ~rst & mem_stall;
    assign take_flush = ~rst & ~mem_stall & ex_redirect;
    assign take_lu    = ~rst & ~mem_stall & ~ex_redirect & load_use;

    // Continuous stalls keep the state in MEM_WAIT with no dead cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_RUN;
        end else begin
            case (state)
                HZ_RUN:      state <= mem_stall ? HZ_MEM_WAIT : HZ_RUN;
                HZ_MEM_WAIT: state <= mem_stall ? HZ_MEM_WAIT : HZ_RUN;
                default:     state <= HZ_RUN;
            endcase
        end
    end

    always_comb begin
        hold_front   = 1'b0;
        hold_back    = 1'b0;
        flush_ifid   = 1'b0;
        bubble_idex  = 1'b0;
        bubble_memwb = 1'b0;
        unique case (1'b1)
            take_stall: begin
                hold_front   = 1'b1;
                hold_back    = 1'b1;
                bubble_memwb = 1'b1;
            end
            take_flush: begin
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end
            take_lu: begin
                hold_front  = 1'b1;
                bubble_idex = 1'b1;
            end
            default: ;
        endcase
    end

    assign seq_state = rst ? HZ_RUN : state;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] lu_q;
    logic [CNT_W-1:0] mw_q;
    logic [CNT_W-1:0] fl_q;

    hz_sat_counter #(.W(CNT_W)) u_cnt_lu (
        .clk   (clk),
        .clr   (rst),
        .en    (take_lu),
        .count (lu_q)
    );

    hz_sat_counter #(.W(CNT_W)) u_cnt_mw (
        .clk   (clk),
        .clr   (rst),
        .en    (take_stall),
        .count (mw_q)
    );

    hz_sat_counter #(.W(CNT_W)) u_cnt_fl (
        .clk   (clk),
        .clr   (rst),
        .en    (take_flush),
        .count (fl_q)
    );

    assign cnt_load_use = rst ? '0 : lu_q;
    assign cnt_mem_wait = rst ? '0 : mw_q;
    assign cnt_flush    = rst ? '0 : fl_q;
`else
    assign cnt_load_use = '0;
    assign cnt_mem_wait = '0;
    assign cnt_flush    = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer; counter checks adapt to HAZ_PERF_CNT_EN.
module tb_hazard_sequencer;
    import hazard_sequencer_pkg::*;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_is_load;
    logic              ex_redirect;
    logic              mem_req;
    logic              mem_ready;
    logic              hold_front;
    logic              hold_back;
    logic              flush_ifid;
    logic              bubble_idex;
    logic              bubble_memwb;
    hz_state_t         seq_state;
    logic [CNT_W-1:0]  cnt_load_use;
    logic [CNT_W-1:0]  cnt_mem_wait;
    logic [CNT_W-1:0]  cnt_flush;

    int checks = 0;
    int errors = 0;

    // {hold_front, hold_back, flush_ifid, bubble_idex, bubble_memwb}
    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_LU    = 5'b10010;
    localparam logic [4:0] O_STALL = 5'b11001;
    localparam logic [4:0] O_FLUSH = 5'b00110;

    hazard_sequencer #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .hold_front   (hold_front),
        .hold_back    (hold_back),
        .flush_ifid   (flush_ifid),
        .bubble_idex  (bubble_idex),
        .bubble_memwb (bubble_memwb),
        .seq_state    (seq_state),
        .cnt_load_use (cnt_load_use),
        .cnt_mem_wait (cnt_mem_wait),
        .cnt_flush    (cnt_flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [4:0] exp_o,
                            input logic [1:0] exp_s);
        #1;
        chk({tag, "_outs"},
            {27'd0, hold_front, hold_back, flush_ifid, bubble_idex,
             bubble_memwb}, {27'd0, exp_o});
        chk({tag, "_state"}, {30'd0, seq_state}, {30'd0, exp_s});
    endtask

    task automatic idle();
        id_rs1      = '0;
        id_rs2      = '0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        ex_rd       = '0;
        ex_is_load  = 1'b0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
    endtask

    initial begin
        idle();
        rst         = 1'b1;
        mem_req     = 1'b1;
        ex_redirect = 1'b1;
        #1;
        chk_outs("rst_early", O_NONE, 2'd0);
        tick();
        tick();
        chk_outs("rst_held", O_NONE, 2'd0);
        chk("rst_cnt_fl", {28'd0, cnt_flush}, 32'd0);
        idle();
        rst = 1'b0;
        tick();
        chk_outs("idle", O_NONE, 2'd0);

        // load-use on rs1, then the load leaves EX
        ex_is_load = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        id_rs2 = 5'd1; id_use_rs2 = 1'b1;
        chk_outs("lu_rs1", O_LU, 2'd0);
        tick();
        ex_is_load = 1'b0;
        chk_outs("lu_after", O_NONE, 2'd0);
        tick();
        ex_is_load = 1'b1; ex_rd = 5'd7;
        id_rs1 = 5'd3; id_rs2 = 5'd7;
        chk_outs("lu_rs2", O_LU, 2'd0);
        tick();

        // x0 never hazards; unused source never hazards
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        chk_outs("lu_x0", O_NONE, 2'd0);
        tick();
        ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;
        chk_outs("lu_nouse", O_NONE, 2'd0);
        tick();
        idle();

        // three wait cycles then release
        mem_req = 1'b1;
        chk_outs("mw_c1", O_STALL, 2'd0);
        tick();
        chk_outs("mw_c2", O_STALL, 2'd1);
        tick();
        chk_outs("mw_c3", O_STALL, 2'd1);
        tick();
        mem_ready = 1'b1;
        chk_outs("mw_rel", O_NONE, 2'd1);
        tick();
        idle();
        chk_outs("mw_done", O_NONE, 2'd0);
        tick();

        // redirect pending during a two-cycle wait
        mem_req = 1'b1; ex_redirect = 1'b1;
        chk_outs("rd_w1", O_STALL, 2'd0);
        tick();
        chk_outs("rd_w2", O_STALL, 2'd1);
        tick();
        mem_ready = 1'b1;
        chk_outs("rd_rel", O_FLUSH, 2'd1);
        tick();
        idle();
        chk_outs("rd_done", O_NONE, 2'd0);
        tick();

        // redirect beats load-use
        ex_redirect = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
        id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        chk_outs("rd_vs_lu", O_FLUSH, 2'd0);
        tick();
        idle();

        // reset in the middle of a wait
        mem_req = 1'b1;
        tick();
        tick();
        chk_outs("pre_rst", O_STALL, 2'd1);
        rst = 1'b1;
        chk_outs("mid_rst", O_NONE, 2'd0);
        chk("mid_rst_cnt_mw", {28'd0, cnt_mem_wait}, 32'd0);
        tick();
        chk_outs("mid_rst2", O_NONE, 2'd0);
        idle();
        rst = 1'b0;
        tick();
        chk_outs("post_rst", O_NONE, 2'd0);
        chk("post_rst_cnt_lu", {28'd0, cnt_load_use}, 32'd0);
        chk("post_rst_cnt_mw", {28'd0, cnt_mem_wait}, 32'd0);
        chk("post_rst_cnt_fl", {28'd0, cnt_flush}, 32'd0);

        // counter increments and saturation
        ex_is_load = 1'b1; ex_rd = 5'd4;
        id_rs1 = 5'd4; id_use_rs1 = 1'b1;
        tick();
        idle();
        mem_req = 1'b1;
        tick();
        tick();
        mem_ready = 1'b1;
        tick();
        idle();
        #1;
        chk("cnt_lu", {28'd0, cnt_load_use}, PERF ? 32'd1 : 32'd0);
        chk("cnt_mw", {28'd0, cnt_mem_wait}, PERF ? 32'd2 : 32'd0);
        ex_redirect = 1'b1;
        repeat (14) tick();
        ex_redirect = 1'b0;
        #1;
        chk("cnt_fl_m1", {28'd0, cnt_flush}, PERF ? 32'd14 : 32'd0);
        ex_redirect = 1'b1;
        repeat (2) tick();
        ex_redirect = 1'b0;
        #1;
        chk("cnt_fl_sat", {28'd0, cnt_flush}, PERF ? 32'd15 : 32'd0);
        chk("cnt_lu_keep", {28'd0, cnt_load_use}, PERF ? 32'd1 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
